// File: rtl/gcd_lcm_coproc.sv
// Multi-cycle GCD/LCM coprocessor: subtractive Euclid, then LCM as (a/g)*b
// using a restoring divider followed by a shift-add multiplier.
module gcd_lcm_coproc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GCD, S_DIV, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   oa_q, oa_d, ob_q, ob_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;

  logic               gcd_term;
  logic [WIDTH-1:0]   g_w;
  logic [WIDTH:0]     rem_shift;
  logic               fits;
  logic [WIDTH-1:0]   rem_next, quo_next;
  logic [2*WIDTH-1:0] acc_next;
  logic               last_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      oa_q     <= '0;
      ob_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      oa_q     <= oa_d;
      ob_q     <= ob_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // In DIV, a_q shifts the dividend out / quotient in and b_q holds the divisor g;
  // in MUL, b_q shifts the multiplier ob right while mcand_q shifts left.
  always_comb begin
    gcd_term  = (a_q == '0) || (b_q == '0) || (a_q == b_q);
    g_w       = (a_q == '0) ? b_q : a_q;
    rem_shift = {rem_q, a_q[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, b_q});
    rem_next  = fits ? (rem_shift[WIDTH-1:0] - b_q) : rem_shift[WIDTH-1:0];
    quo_next  = {a_q[WIDTH-2:0], fits};
    acc_next  = b_q[0] ? (acc_q + mcand_q) : acc_q;
    last_cnt  = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    oa_d     = oa_q;
    ob_d     = ob_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          oa_d    = src_a;
          ob_d    = src_b;
          a_d     = src_a;
          b_d     = src_b;
          state_d = S_GCD;
        end
      end
      S_GCD: begin
        if (gcd_term) begin
          if (!op_q) begin
            result_d = g_w;
            ovf_d    = 1'b0;
            state_d  = S_DONE;
          end else if ((oa_q == '0) || (ob_q == '0)) begin
            result_d = '0;
            ovf_d    = 1'b0;
            state_d  = S_DONE;
          end else begin
            a_d     = oa_q;
            b_d     = g_w;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_DIV;
          end
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      S_DIV: begin
        rem_d = rem_next;
        a_d   = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (last_cnt) begin
          mcand_d = {{WIDTH{1'b0}}, quo_next};
          b_d     = ob_q;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d   = acc_next;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_cnt) begin
          result_d = acc_next[WIDTH-1:0];
          ovf_d    = |acc_next[2*WIDTH-1:WIDTH];
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q == S_GCD) || (state_q == S_DIV) || (state_q == S_MUL);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Scoreboard bench for gcd_lcm_coproc: the driver queues expected responses,
// a monitor pops and checks them on every done pulse.
module tb_gcd_lcm_coproc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, ovf;
  logic [W-1:0] result;

  gcd_lcm_coproc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ov;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: cycle k after the accepting edge has cyc == acc + k - 1.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual_result=%0h required=no_done", result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", {32'h0, result}, {32'h0, mon_e.res});
        chk("ovf", {63'h0, ovf}, {63'h0, mon_e.ov});
        chk("latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
        chk("busy_in_done", {63'h0, busy}, 64'h0);
        $display("txn result=%08h ovf=%0b latency=%0d exp_result=%08h exp_ovf=%0b exp_latency=%0d",
                 result, ovf, cyc - mon_e.acc + 1, mon_e.res, mon_e.ov, mon_e.lat);
      end
    end
  end

  task automatic drive(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
  endtask

  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic ov, input int lat, input bit push);
    @(negedge clk);
    drive(o, a, b);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb.push_back('{res: res, ov: ov, lat: lat, acc: cyc});
  endtask

  task automatic wait_done();
    int target;
    int n;
    target = done_count + 1;
    n = 0;
    while (done_count < target && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_count < target) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_400");
    end
  endtask

  task automatic run(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] res, input logic ov, input int lat);
    issue(o, a, b, res, ov, lat, 1'b1);
    wait_done();
  endtask

  initial begin
    int dc;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_result", {32'h0, result}, 64'h0);
    chk("reset_ovf", {63'h0, ovf}, 64'h0);
    reset = 1'b1;

    // GCD(12,8) with busy tracked through cycles 1-3
    issue(1'b0, 32'd12, 32'd8, 32'd4, 1'b0, 4, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("busy_gcd_cycle", {63'h0, busy}, 64'h1);
    end
    wait_done();

    run(1'b1, 32'd4, 32'd6, 32'd12, 1'b0, 68);
    run(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 2);
    run(1'b0, 32'd0, 32'd9, 32'd9, 1'b0, 2);
    run(1'b0, 32'd9, 32'd0, 32'd9, 1'b0, 2);
    run(1'b1, 32'd0, 32'd7, 32'd0, 1'b0, 2);
    run(1'b1, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b1, 68);
    run(1'b0, 32'd48, 32'd18, 32'd6, 1'b0, 6);
    run(1'b1, 32'd21, 32'd6, 32'd42, 1'b0, 70);
    run(1'b0, 32'd1, 32'd5, 32'd1, 1'b0, 6);

    // start while busy and during DONE is ignored
    issue(1'b0, 32'd12, 32'd8, 32'd4, 1'b0, 4, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'd9, 32'd3);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    dc = done_count;
    drive(1'b1, 32'd100, 32'd75);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ignored_start_busy", {63'h0, busy}, 64'h0);
    chk("ignored_start_done_count", 64'(done_count), 64'(dc));

    // back-to-back issue in the cycle after DONE
    run(1'b0, 32'd48, 32'd18, 32'd6, 1'b0, 6);
    drive(1'b1, 32'd21, 32'd6);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{res: 32'd42, ov: 1'b0, lat: 70, acc: cyc});
    @(negedge clk);
    chk("held_result", {32'h0, result}, 64'd6);
    chk("b2b_busy", {63'h0, busy}, 64'h1);
    wait_done();

    // asynchronous reset mid-DIV of LCM(4,6)
    issue(1'b1, 32'd4, 32'd6, 32'd12, 1'b0, 68, 1'b0);
    dc = done_count;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    chk("abort_result", {32'h0, result}, 64'h0);
    chk("abort_ovf", {63'h0, ovf}, 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (70) @(negedge clk);
    chk("abort_no_done", 64'(done_count), 64'(dc));
    run(1'b0, 32'd12, 32'd8, 32'd4, 1'b0, 4);

    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
